shift_unit_arbiter: RTL and testbench

//  Shares the single combinational 32-bit shifter between two requesters (0 = integer pipe, 1 = aux/CSR path).

---
 rtl/shift_unit_arbiter.sv | 157 +++++++++++++++
 tb/tb_shift_unit_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_unit_arbiter.sv
// shift_unit_arbiter
//   Shares one external combinational 32-bit shifter between two requesters
//   (0 = integer pipe, 1 = aux/CSR path). A round-robin arbiter accepts one
//   request, registers its operands onto the shifter inputs, captures the
//   shifter output one cycle later and returns it with the requester's tag
//   over a valid/ready response channel. Only one operation is in flight.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready [2]    request handshake, bit i = requester i
//   req_a/hsel/shamt/tag       per-requester operands, requester i in slice i
//   sh_a/sh_hsel/sh_shamt      registered operands driven to the shifter
//   sh_h                       shifter result
//   rsp_valid/rsp_ready [2]    response handshake, one-hot on the owner
//   rsp_data/rsp_tag           result and echoed tag (qualify with rsp_valid)
//   busy                       high whenever an operation is in flight
//   op_count                   completed operations, wraps at 16 bits
module shift_unit_arbiter #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5,
  parameter int TAG_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [2*DATA_W-1:0]  req_a,
  input  logic [3:0]           req_hsel,
  input  logic [2*SHAMT_W-1:0] req_shamt,
  input  logic [2*TAG_W-1:0]   req_tag,
  output logic [DATA_W-1:0]    sh_a,
  output logic [1:0]           sh_hsel,
  output logic [SHAMT_W-1:0]   sh_shamt,
  input  logic [DATA_W-1:0]    sh_h,
  output logic [1:0]           rsp_valid,
  input  logic [1:0]           rsp_ready,
  output logic [DATA_W-1:0]    rsp_data,
  output logic [TAG_W-1:0]     rsp_tag,
  output logic                 busy,
  output logic [15:0]          op_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                gid_q, gid_d;
  logic [DATA_W-1:0]   op_a_q, op_a_d;
  logic [1:0]          op_hsel_q, op_hsel_d;
  logic [SHAMT_W-1:0]  op_shamt_q, op_shamt_d;
  logic [TAG_W-1:0]    op_tag_q, op_tag_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [15:0]         op_count_q, op_count_d;

  logic                grant_vld;
  logic                grant_id;
  logic                idle;

  assign idle = (state_q == S_IDLE);

  // Round-robin pick: a lone requester wins outright; on contention the
  // requester that did not complete last goes first.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    case (req_valid)
      2'b01:   begin grant_vld = 1'b1; grant_id = 1'b0;          end
      2'b10:   begin grant_vld = 1'b1; grant_id = 1'b1;          end
      2'b11:   begin grant_vld = 1'b1; grant_id = ~last_grant_q; end
      default: begin grant_vld = 1'b0; grant_id = 1'b0;          end
    endcase
  end

  // Ready is offered only in IDLE and never looks at the response side.
  assign req_ready[0] = idle & grant_vld & ~grant_id;
  assign req_ready[1] = idle & grant_vld &  grant_id;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gid_d        = gid_q;
    op_a_d       = op_a_q;
    op_hsel_d    = op_hsel_q;
    op_shamt_d   = op_shamt_q;
    op_tag_d     = op_tag_q;
    result_d     = result_q;
    op_count_d   = op_count_q;
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          gid_d      = grant_id;
          op_a_d     = grant_id ? req_a[2*DATA_W-1:DATA_W]       : req_a[DATA_W-1:0];
          op_hsel_d  = grant_id ? req_hsel[3:2]                  : req_hsel[1:0];
          op_shamt_d = grant_id ? req_shamt[2*SHAMT_W-1:SHAMT_W] : req_shamt[SHAMT_W-1:0];
          op_tag_d   = grant_id ? req_tag[2*TAG_W-1:TAG_W]       : req_tag[TAG_W-1:0];
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // Shifter inputs have been stable for a full cycle; take its output.
        result_d = sh_h;
        state_d  = S_RESP;
      end
      S_RESP: begin
        // Only the owner's ready completes the response.
        if (rsp_ready[gid_q]) begin
          last_grant_d = gid_q;
          op_count_d   = op_count_q + 16'd1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      gid_q        <= 1'b0;
      op_a_q       <= '0;
      op_hsel_q    <= '0;
      op_shamt_q   <= '0;
      op_tag_q     <= '0;
      result_q     <= '0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gid_q        <= gid_d;
      op_a_q       <= op_a_d;
      op_hsel_q    <= op_hsel_d;
      op_shamt_q   <= op_shamt_d;
      op_tag_q     <= op_tag_d;
      result_q     <= result_d;
      op_count_q   <= op_count_d;
    end
  end

  // Shifter is fed only from the operand registers, so its inputs hold
  // steady through SHIFT and RESP regardless of what requesters do.
  assign sh_a     = op_a_q;
  assign sh_hsel  = op_hsel_q;
  assign sh_shamt = op_shamt_q;

  assign rsp_valid[0] = (state_q == S_RESP) & ~gid_q;
  assign rsp_valid[1] = (state_q == S_RESP) &  gid_q;
  assign rsp_data     = result_q;
  assign rsp_tag      = op_tag_q;
  assign busy         = ~idle;
  assign op_count     = op_count_q;

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// tb_shift_unit_arbiter
//   Directed bench for shift_unit_arbiter. A behavioural model of the shared
//   32-bit shifter closes the sh_* loop; expected results are hand-computed.
module tb_shift_unit_arbiter;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;
  localparam int TAG_W   = 4;

  logic                 clk;
  logic                 rst_n;
  logic [1:0]           req_valid;
  logic [1:0]           req_ready;
  logic [2*DATA_W-1:0]  req_a;
  logic [3:0]           req_hsel;
  logic [2*SHAMT_W-1:0] req_shamt;
  logic [2*TAG_W-1:0]   req_tag;
  logic [DATA_W-1:0]    sh_a;
  logic [1:0]           sh_hsel;
  logic [SHAMT_W-1:0]   sh_shamt;
  logic [DATA_W-1:0]    sh_h;
  logic [1:0]           rsp_valid;
  logic [1:0]           rsp_ready;
  logic [DATA_W-1:0]    rsp_data;
  logic [TAG_W-1:0]     rsp_tag;
  logic                 busy;
  logic [15:0]          op_count;

  int checks = 0;
  int errors = 0;

  shift_unit_arbiter #(
    .DATA_W (DATA_W),
    .SHAMT_W(SHAMT_W),
    .TAG_W  (TAG_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_hsel (req_hsel),
    .req_shamt(req_shamt),
    .req_tag  (req_tag),
    .sh_a     (sh_a),
    .sh_hsel  (sh_hsel),
    .sh_shamt (sh_shamt),
    .sh_h     (sh_h),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_tag  (rsp_tag),
    .busy     (busy),
    .op_count (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared shifter: 0 SLL, 1 SRL, 2 pass-through, 3 SRA.
  always_comb begin
    case (sh_hsel)
      2'd0:    sh_h = sh_a << sh_shamt;
      2'd1:    sh_h = sh_a >> sh_shamt;
      2'd2:    sh_h = sh_a;
      default: sh_h = $unsigned($signed(sh_a) >>> sh_shamt);
    endcase
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [31:0] a, input logic [1:0] hsel,
                         input logic [4:0] shamt, input logic [3:0] tag);
    if (id == 0) begin
      req_a[31:0] = a; req_hsel[1:0] = hsel; req_shamt[4:0] = shamt; req_tag[3:0] = tag;
    end else begin
      req_a[63:32] = a; req_hsel[3:2] = hsel; req_shamt[9:5] = shamt; req_tag[7:4] = tag;
    end
  endtask

  // One complete lone-requester transaction, entered and left at a negedge in IDLE.
  task automatic run_op(input int id, input logic [31:0] a, input logic [1:0] hsel,
                        input logic [4:0] shamt, input logic [3:0] tag,
                        input logic [31:0] exp, input string name);
    logic [1:0] oh;
    oh = (id == 0) ? 2'b01 : 2'b10;
    set_req(id, a, hsel, shamt, tag);
    req_valid = oh;
    #1 chk({name, "_req_ready"}, req_ready, oh);
    @(negedge clk);
    req_valid = 2'b00;
    chk({name, "_shift_rsp_valid"}, rsp_valid, 2'b00);
    @(negedge clk);
    chk({name, "_rsp_valid"}, rsp_valid, oh);
    chk({name, "_rsp_data"}, rsp_data, exp);
    chk({name, "_rsp_tag"}, rsp_tag, tag);
    rsp_ready = oh;
    @(negedge clk);
    rsp_ready = 2'b00;
    chk({name, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 2'b00; req_a = '0; req_hsel = '0;
    req_shamt = '0; req_tag = '0; rsp_ready = 2'b00;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_busy", busy, 1'b0);
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_op_count", op_count, 16'd0);
    chk("rst_sh_a", sh_a, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: req0 SLL 0xF0 by 4
    set_req(0, 32'h0000_00F0, 2'd0, 5'd4, 4'd3);
    req_valid = 2'b01;
    #1 chk("t1_req_ready", req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    chk("t1_busy", busy, 1'b1);
    chk("t1_shift_ready", req_ready, 2'b00);
    chk("t1_shift_rsp_valid", rsp_valid, 2'b00);
    chk("t1_sh_a", sh_a, 32'h0000_00F0);
    chk("t1_sh_shamt", sh_shamt, 5'd4);
    @(negedge clk);
    chk("t1_rsp_valid", rsp_valid, 2'b01);
    chk("t1_rsp_data", rsp_data, 32'h0000_0F00);
    chk("t1_rsp_tag", rsp_tag, 4'd3);
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
    chk("t1_idle", busy, 1'b0);
    chk("t1_rsp_valid_off", rsp_valid, 2'b00);
    chk("t1_op_count", op_count, 16'd1);
    chk("t1_data_hold", rsp_data, 32'h0000_0F00);

    // T2: shift modes on requester 1, plus shamt=0 identity on requester 0
    run_op(1, 32'h8000_0000, 2'd3, 5'd31, 4'd5, 32'hFFFF_FFFF, "t2_sra");
    run_op(1, 32'h8000_0000, 2'd1, 5'd31, 4'd6, 32'h0000_0001, "t2_srl");
    run_op(1, 32'h8000_0000, 2'd2, 5'd7,  4'd7, 32'h8000_0000, "t2_pass");
    run_op(0, 32'h1234_5678, 2'd3, 5'd0,  4'd8, 32'h1234_5678, "t2_sh0");
    chk("t2_op_count", op_count, 16'd5);

    // T3: both requesters valid from reset -> 0,1,0,1
    rst_n = 1'b0;
    set_req(0, 32'h0000_0001, 2'd0, 5'd1, 4'hA);
    set_req(1, 32'h0000_0010, 2'd1, 5'd1, 4'hB);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    @(negedge clk);
    chk("t3_rst_op_count", op_count, 16'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (k % 2 == 0) chk("t3_grant0", req_ready, 2'b01);
      else            chk("t3_grant1", req_ready, 2'b10);
      @(negedge clk);
      chk("t3_busy", busy, 1'b1);
      @(negedge clk);
      if (k % 2 == 0) begin
        chk("t3_rsp_valid0", rsp_valid, 2'b01);
        chk("t3_rsp_data0", rsp_data, 32'h0000_0002);
        chk("t3_rsp_tag0", rsp_tag, 4'hA);
      end else begin
        chk("t3_rsp_valid1", rsp_valid, 2'b10);
        chk("t3_rsp_data1", rsp_data, 32'h0000_0008);
        chk("t3_rsp_tag1", rsp_tag, 4'hB);
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    chk("t3_op_count", op_count, 16'd4);

    // T4: response back-pressure for 5 cycles
    set_req(0, 32'h0F0F_0F0F, 2'd1, 5'd4, 4'd9);
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    req_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4_rsp_valid", rsp_valid, 2'b01);
      chk("t4_rsp_data", rsp_data, 32'h00F0_F0F0);
      chk("t4_rsp_tag", rsp_tag, 4'd9);
      chk("t4_req_ready", req_ready, 2'b00);
      chk("t4_busy", busy, 1'b1);
      @(negedge clk);
    end
    req_valid = 2'b00;
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
    chk("t4_idle", busy, 1'b0);
    chk("t4_op_count", op_count, 16'd5);

    // T5: reset during SHIFT discards the operation
    set_req(1, 32'hDEAD_BEEF, 2'd2, 5'd0, 4'hC);
    req_valid = 2'b10;
    @(negedge clk);
    req_valid = 2'b00;
    chk("t5_busy_shift", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t5_busy", busy, 1'b0);
    chk("t5_sh_a", sh_a, 32'd0);
    chk("t5_sh_hsel", sh_hsel, 2'd0);
    chk("t5_rsp_valid", rsp_valid, 2'b00);
    chk("t5_rsp_tag", rsp_tag, 4'd0);
    chk("t5_op_count", op_count, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_no_rsp", rsp_valid, 2'b00);
      chk("t5_no_busy", busy, 1'b0);
    end
    rsp_ready = 2'b00;
    chk("t5_op_count_after", op_count, 16'd0);

    // T6: counter wrap and wrong-bit response ready
    force dut.op_count_q = 16'hFFFE;
    #1 release dut.op_count_q;
    @(negedge clk);
    chk("t6_preload", op_count, 16'hFFFE);
    run_op(0, 32'h0000_0003, 2'd0, 5'd2, 4'd1, 32'h0000_000C, "t6_op");
    chk("t6_op_count_ffff", op_count, 16'hFFFF);
    set_req(0, 32'hF000_0000, 2'd3, 5'd4, 4'd2);
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    rsp_ready = 2'b10;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_wrong_ready_valid", rsp_valid, 2'b01);
      chk("t6_wrong_ready_count", op_count, 16'hFFFF);
    end
    chk("t6_rsp_data", rsp_data, 32'hFF00_0000);
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
    chk("t6_wrap", op_count, 16'h0000);
    chk("t6_idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
